// File: rtl/sound_trigger_bank_pkg.sv
// Shared definitions for the sound trigger bank: output mode codes and the
// per-channel trigger FSM state encoding.
package sound_pkg;

    localparam logic [1:0] MODE_PULSE  = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_LEVEL  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } chan_state_e;

endpackage

// File: rtl/sound_trigger_bank_channel.sv
// One sensor channel: input synchroniser, optional rising-edge qualifier,
// IDLE/LOCK acceptance FSM with lockout counter, toggle and saturating event count.
module trigger_channel
    import sound_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int LOCK_W         = 26,
    parameter int SYNC_STAGES    = 2,
    parameter int TRIG_EDGE      = 0,
    parameter int EVT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             chan_en,
    input  logic             clear,
    output logic             trig_pulse,
    output logic             toggle,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    chan_state_e            state_q, state_d;
    logic [LOCK_W-1:0]      cnt_q, cnt_d;
    logic                   trig_q, trig_d;
    logic                   tog_q, tog_d;
    logic [EVT_W-1:0]       evt_q, evt_d;
    logic                   synced, hit, expire;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            tog_q   <= 1'b0;
            evt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], data_in};
            prev_q  <= synced;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            tog_q   <= tog_d;
            evt_q   <= evt_d;
        end
    end

    // The last lockout cycle also acts as an IDLE decision, so a held input
    // re-accepts exactly LOCKOUT_CYCLES after the previous accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        tog_d   = tog_q;
        evt_d   = evt_q;
        expire  = (state_q == ST_LOCK) && (cnt_q == LOCK_LAST);
        hit     = chan_en && synced && ((TRIG_EDGE == 0) || !prev_q);
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tog_d   = 1'b0;
            evt_d   = '0;
        end else if (hit && ((state_q == ST_IDLE) || expire)) begin
            state_d = ST_LOCK;
            cnt_d   = '0;
            trig_d  = 1'b1;
            tog_d   = !tog_q;
            if (evt_q != '1) evt_d = evt_q + EVT_W'(1);
        end else if (state_q == ST_LOCK) begin
            if (expire) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + LOCK_W'(1);
            end
        end
    end

    assign trig_pulse = trig_q;
    assign toggle     = tog_q;
    assign busy       = (state_q == ST_LOCK);
    assign evt_cnt    = evt_q;

endmodule

// File: rtl/sound_trigger_bank.sv
// Multi-channel sound trigger: independent trigger_channel instances, a shared
// output-mode mux over registered sources, and flattened event counts.
module sound_trigger_bank
    import sound_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int LOCK_W         = 26,
    parameter int SYNC_STAGES    = 2,
    parameter int TRIG_EDGE      = 0,
    parameter int EVT_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       data_in,
    input  logic [CHANNELS-1:0]       chan_en,
    input  logic [1:0]                mode,
    input  logic                      clear,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       trig_pulse,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*EVT_W-1:0] evt_cnt
);

    logic [CHANNELS-1:0] toggle;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        trigger_channel #(
            .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
            .LOCK_W        (LOCK_W),
            .SYNC_STAGES   (SYNC_STAGES),
            .TRIG_EDGE     (TRIG_EDGE),
            .EVT_W         (EVT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .data_in   (data_in[g]),
            .chan_en   (chan_en[g]),
            .clear     (clear),
            .trig_pulse(trig_pulse[g]),
            .toggle    (toggle[g]),
            .busy      (busy[g]),
            .evt_cnt   (evt_cnt[g*EVT_W +: EVT_W])
        );
    end

    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            case (mode)
                MODE_PULSE:        out[i] = trig_pulse[i];
                MODE_LEVEL:        out[i] = busy[i];
                MODE_TOGGLE, 2'b11: out[i] = toggle[i];
            endcase
        end
    end

endmodule

// File: tb/tb_sound_trigger_bank.sv
// Self-checking bench: two bank instances (level and edge triggering) compared
// cycle by cycle against an edge-numbered behavioural model, plus directed checks.
module tb_sound_trigger_bank;

    localparam int CH   = 4;
    localparam int LOCK = 8;
    localparam int SYNC = 2;
    localparam int EW   = 4;
    localparam int VW   = 3*CH + CH*EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] data_in = '0;
    logic [CH-1:0] chan_en = '0;
    logic [1:0]    mode = 2'b00;
    logic          clear = 1'b0;

    logic [CH-1:0]    out, trig_pulse, busy;
    logic [CH*EW-1:0] evt_cnt;
    logic [CH-1:0]    out_e, trig_e, busy_e;
    logic [CH*EW-1:0] evt_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sound_trigger_bank #(
        .CHANNELS(CH), .LOCKOUT_CYCLES(LOCK), .LOCK_W(4),
        .SYNC_STAGES(SYNC), .TRIG_EDGE(0), .EVT_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .chan_en(chan_en),
        .mode(mode), .clear(clear), .out(out), .trig_pulse(trig_pulse),
        .busy(busy), .evt_cnt(evt_cnt)
    );

    sound_trigger_bank #(
        .CHANNELS(CH), .LOCKOUT_CYCLES(LOCK), .LOCK_W(4),
        .SYNC_STAGES(SYNC), .TRIG_EDGE(1), .EVT_W(EW)
    ) dut_e (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .chan_en(chan_en),
        .mode(mode), .clear(clear), .out(out_e), .trig_pulse(trig_e),
        .busy(busy_e), .evt_cnt(evt_e)
    );

    // Reference model: edge-numbered acceptance times; index 0 level, 1 edge triggered
    logic [CH-1:0] m_hist [SYNC+1];
    int            ecount = 0;
    int            m_last  [2][CH];
    int            m_evt   [2][CH];
    bit            m_have  [2][CH];
    bit            m_tog   [2][CH];
    bit            m_pulse [2][CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC; i++) m_hist[i] = '0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    m_last[k][c] = 0; m_evt[k][c] = 0; m_have[k][c] = 0;
                    m_tog[k][c] = 0; m_pulse[k][c] = 0;
                end
        end else begin
            ecount++;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    bit s, p, locked;
                    s = m_hist[SYNC-1][c];
                    p = m_hist[SYNC][c];
                    locked = m_have[k][c] && (ecount - m_last[k][c] < LOCK);
                    m_pulse[k][c] = 0;
                    if (clear) begin
                        m_have[k][c] = 0; m_tog[k][c] = 0; m_evt[k][c] = 0;
                    end else if (!locked && chan_en[c] && s && (k == 0 || !p)) begin
                        m_pulse[k][c] = 1;
                        m_tog[k][c] = !m_tog[k][c];
                        if (m_evt[k][c] < (1 << EW) - 1) m_evt[k][c]++;
                        m_last[k][c] = ecount;
                        m_have[k][c] = 1;
                    end
                end
            for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = data_in;
        end
    end

    function automatic logic [VW-1:0] exp_vec(input int k);
        logic [CH-1:0]    o, t, b;
        logic [CH*EW-1:0] e;
        for (int c = 0; c < CH; c++) begin
            t[c] = m_pulse[k][c];
            b[c] = m_have[k][c] && (ecount - m_last[k][c] < LOCK);
            e[c*EW +: EW] = EW'(m_evt[k][c]);
            case (mode)
                2'b00:   o[c] = t[c];
                2'b10:   o[c] = b[c];
                default: o[c] = m_tog[k][c];
            endcase
        end
        return {o, t, b, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({out, trig_pulse, busy, evt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", {out, trig_pulse, busy, evt_cnt});
        end
        rst_n = 1'b1;
        chan_en = '1;
        repeat (2) begin
            tick();
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL reset_release: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
        end
    endtask

    task automatic test_single_pulse();
        int first = -1, pulses = 0, busy_n = 0;
        mode = 2'b00;
        data_in[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) data_in[0] = 1'b0;
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL single_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            if (trig_pulse[0]) begin pulses++; if (first < 0) first = i; end
            if (busy[0]) busy_n++;
        end
        checks++;
        if (first !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", first); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", pulses); end
        checks++;
        if (busy_n !== LOCK) begin errors++; $display("FAIL single_busy: got %0d expected %0d", busy_n, LOCK); end
    endtask

    task automatic test_held_level();
        int p0 = 0, p1 = 0, last = -1, bad_gap = 0;
        clear = 1'b1; tick(); clear = 1'b0;
        data_in[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 39) data_in[1] = 1'b0;
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL held_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            checks++;
            if ({out_e, trig_e, busy_e, evt_e} !== exp_vec(1)) begin
                errors++;
                $display("FAIL held_edge_model: got %h expected %h", {out_e, trig_e, busy_e, evt_e}, exp_vec(1));
            end
            if (trig_pulse[1]) begin
                if (last >= 0 && i - last != LOCK) bad_gap++;
                last = i; p0++;
            end
            if (trig_e[1]) p1++;
        end
        checks++;
        if (p0 !== 5) begin errors++; $display("FAIL held_accepts: got %0d expected 5", p0); end
        checks++;
        if (bad_gap !== 0) begin errors++; $display("FAIL held_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++;
        if (evt_cnt[7:4] !== 4'd5) begin errors++; $display("FAIL held_evt: got %0d expected 5", evt_cnt[7:4]); end
        checks++;
        if (p1 !== 1) begin errors++; $display("FAIL held_edge_accepts: got %0d expected 1", p1); end
    endtask

    task automatic test_toggle();
        int trans = 0;
        logic prev;
        mode = 2'b01;
        clear = 1'b1; tick(); clear = 1'b0;
        prev = out[2];
        for (int i = 0; i < 30; i++) begin
            data_in[2] = (i == 0 || i == 4 || i == 10 || i == 20);
            tick();
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL toggle_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            if (out[2] !== prev) trans++;
            prev = out[2];
        end
        data_in[2] = 1'b0;
        checks++;
        if (trans !== 3 || out[2] !== 1'b1) begin
            errors++;
            $display("FAIL toggle_seq: got %0d transitions final %b expected 3 final 1", trans, out[2]);
        end
    endtask

    task automatic test_saturate_clear();
        mode = 2'b10;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 195; i++) begin
            data_in[3] = (i % 10 == 0);
            tick();
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL sat_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
        end
        data_in[3] = 1'b0;
        checks++;
        if (evt_cnt[15:12] !== 4'd15 || busy[3] !== 1'b1) begin
            errors++;
            $display("FAIL sat_evt: got %0d busy %b expected 15 busy 1", evt_cnt[15:12], busy[3]);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if ({out, busy, evt_cnt} !== '0) begin
            errors++;
            $display("FAIL clear_state: got %h expected 0", {out, busy, evt_cnt});
        end
    endtask

    task automatic test_enable_simul();
        int p = 0, all = 0;
        mode = 2'b00;
        chan_en = 4'b1110;
        data_in[0] = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i == 11) data_in[0] = 1'b0;
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL enable_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            if (trig_pulse[0]) p++;
        end
        checks++;
        if (p !== 0) begin errors++; $display("FAIL enable_block: got %0d pulses expected 0", p); end
        chan_en = '1;
        data_in = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            data_in = '0;
            if (trig_pulse === 4'hF) all++;
        end
        checks++;
        if (all !== 1) begin errors++; $display("FAIL simultaneous: got %0d all-channel pulses expected 1", all); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) data_in[c] = ($urandom_range(3) == 0);
            if (i % 16 == 0) mode = 2'($urandom_range(3));
            if (i % 8 == 0) chan_en = 4'($urandom_range(15)) | 4'b1001;
            clear = ($urandom_range(39) == 0);
            tick();
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_level: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            checks++;
            if ({out_e, trig_e, busy_e, evt_e} !== exp_vec(1)) begin
                errors++;
                $display("FAIL random_edge: got %h expected %h", {out_e, trig_e, busy_e, evt_e}, exp_vec(1));
            end
        end
        clear = 1'b0;
        data_in = '0;
        chan_en = '1;
        repeat (LOCK + 4) tick();
    endtask

    task automatic test_reset_midlock();
        int p = 0;
        mode = 2'b10;
        data_in[0] = 1'b1; tick(); data_in[0] = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL midlock_busy: got %b expected 1", busy[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out, trig_pulse, busy_e} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {busy, out, trig_pulse, busy_e});
        end
        #2 rst_n = 1'b1;
        tick();
        mode = 2'b00;
        data_in[0] = 1'b1; tick(); data_in[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({out, trig_pulse, busy, evt_cnt} !== exp_vec(0)) begin
                errors++;
                $display("FAIL post_reset_model: got %h expected %h", {out, trig_pulse, busy, evt_cnt}, exp_vec(0));
            end
            if (trig_pulse[0]) p++;
            tick();
        end
        checks++;
        if (p !== 1) begin errors++; $display("FAIL post_reset_accept: got %0d expected 1", p); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_held_level();
        test_toggle();
        test_saturate_clear();
        test_enable_simul();
        test_random();
        test_reset_midlock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
